// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM stage: load-op encoding, field widths and
// the EX->MS / MS->WS bus widths used by the neighbouring bus packers.
package mem_stage_lsu_pkg;

  localparam int REG_W      = 32;
  localparam int PC_W       = 32;
  localparam int DEST_W     = 5;
  localparam int ADDR_LOW_W = 3;
  localparam int LOAD_OP_W  = 3;
  localparam int RF_WE_W    = 4;

  typedef enum logic [LOAD_OP_W-1:0] {
    LOAD_LW  = 3'd0,
    LOAD_LB  = 3'd1,
    LOAD_LBU = 3'd2,
    LOAD_LH  = 3'd3,
    LOAD_LHU = 3'd4,
    LOAD_LWL = 3'd5,
    LOAD_LWR = 3'd6,
    LOAD_RSV = 3'd7
  } load_op_e;

  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [ADDR_LOW_W-1:0] addr_low;
    load_op_e              load_op;
    logic                  res_from_mem;
    logic                  req_sent;
    logic                  gr_we;
    logic [DEST_W-1:0]     dest;
    logic [REG_W-1:0]      alu_result;
  } es_payload_t;

  localparam int ES_TO_MS_BUS_W = $bits(es_payload_t);
  localparam int MS_TO_WS_BUS_W = RF_WE_W + DEST_W + REG_W + PC_W;

  function automatic logic [REG_W-1:0] ext16(input logic [15:0] v, input logic sgn);
    return {{16{sgn & v[15]}}, v};
  endfunction

  function automatic logic [REG_W-1:0] ext8(input logic [7:0] v, input logic sgn);
    return {{24{sgn & v[7]}}, v};
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// EX/memory/WB-facing signal bundle of the MEM stage; the slave modport is the
// stage itself, the master modport is whatever surrounds it.
interface mem_stage_lsu_if #(parameter int DW = 32);
  import mem_stage_lsu_pkg::*;

  logic                  flush;
  logic                  es_to_ms_valid;
  logic                  ms_allowin;
  logic [PC_W-1:0]       es_pc;
  logic [ADDR_LOW_W-1:0] es_addr_low;
  logic [LOAD_OP_W-1:0]  es_load_op;
  logic                  es_res_from_mem;
  logic                  es_req_sent;
  logic                  es_cancel_req;
  logic                  es_gr_we;
  logic [DEST_W-1:0]     es_dest;
  logic [REG_W-1:0]      es_alu_result;
  logic [DW-1:0]         data_rdata;
  logic                  data_data_ok;
  logic                  ws_allowin;
  logic                  ms_to_ws_valid;
  logic [RF_WE_W-1:0]    ms_rf_we;
  logic [DEST_W-1:0]     ms_dest;
  logic [REG_W-1:0]      ms_result;
  logic [PC_W-1:0]       ms_pc;
  logic                  ms_valid;
  logic                  ms_fwd_valid;
  logic                  ms_fwd_block;

  modport slave (
    input  flush, es_to_ms_valid, es_pc, es_addr_low, es_load_op, es_res_from_mem,
           es_req_sent, es_cancel_req, es_gr_we, es_dest, es_alu_result,
           data_rdata, data_data_ok, ws_allowin,
    output ms_allowin, ms_to_ws_valid, ms_rf_we, ms_dest, ms_result, ms_pc,
           ms_valid, ms_fwd_valid, ms_fwd_block
  );

  modport master (
    output flush, es_to_ms_valid, es_pc, es_addr_low, es_load_op, es_res_from_mem,
           es_req_sent, es_cancel_req, es_gr_we, es_dest, es_alu_result,
           data_rdata, data_data_ok, ws_allowin,
    input  ms_allowin, ms_to_ws_valid, ms_rf_we, ms_dest, ms_result, ms_pc,
           ms_valid, ms_fwd_valid, ms_fwd_block
  );

endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// Combinational load aligner: picks the addressed byte/half/word out of a
// 32-bit lane, extends it, and produces per-byte GPR write enables.
module mem_load_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [REG_W-1:0]   lane_i,
  input  logic [1:0]         k_i,
  input  load_op_e           load_op_i,
  input  logic               gr_we_i,
  output logic [REG_W-1:0]   aligned_o,
  output logic [RF_WE_W-1:0] rf_we_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    byte_w    = lane_i[{k_i, 3'b000} +: 8];
    half_w    = lane_i[{k_i[1], 4'b0000} +: 16];
    aligned_o = lane_i;
    rf_we_o   = {RF_WE_W{gr_we_i}};
    case (load_op_i)
      LOAD_LB:  aligned_o = ext8(byte_w, 1'b1);
      LOAD_LBU: aligned_o = ext8(byte_w, 1'b0);
      LOAD_LH:  aligned_o = ext16(half_w, 1'b1);
      LOAD_LHU: aligned_o = ext16(half_w, 1'b0);
      // Unaligned halves: only the bytes that came from memory get written.
      LOAD_LWL: begin
        aligned_o = lane_i << {(2'd3 - k_i), 3'b000};
        rf_we_o   = (4'b1111 << (2'd3 - k_i)) & {RF_WE_W{gr_we_i}};
      end
      LOAD_LWR: begin
        aligned_o = lane_i >> {k_i, 3'b000};
        rf_we_o   = (4'b1111 >> k_i) & {RF_WE_W{gr_we_i}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage with variable-latency data response, one-entry response buffer,
// flush with stale-response discard, and ID forwarding/stall outputs.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int DW       = 32,
  parameter int CANCEL_W = 2
) (
  input logic            clk,
  input logic            reset,
  mem_stage_lsu_if.slave bus
);

  es_payload_t         pl_q, pl_d;
  logic                ms_valid_q, ms_valid_d;
  logic                buf_valid_q, buf_valid_d;
  logic [REG_W-1:0]    buf_data_q, buf_data_d;
  logic [CANCEL_W-1:0] cnt_q, cnt_d;
  logic [CANCEL_W:0]   cnt_sum;

  logic                wait_w, resp_mine, stale_ok, ready_go, allowin, leave;
  logic [REG_W-1:0]    lane_w, src_w, aligned_w;
  logic [RF_WE_W-1:0]  rf_we_w;

  if (DW == 64) begin : g_lane64
    assign lane_w = bus.data_rdata[{pl_q.addr_low[2], 5'b00000} +: 32];
  end else begin : g_lane32
    logic unused_addr2;
    assign unused_addr2 = pl_q.addr_low[2];
    assign lane_w       = bus.data_rdata[31:0];
  end

  assign src_w = buf_valid_q ? buf_data_q : lane_w;

  mem_load_align u_align (
    .lane_i    (src_w),
    .k_i       (pl_q.addr_low[1:0]),
    .load_op_i (pl_q.load_op),
    .gr_we_i   (pl_q.gr_we),
    .aligned_o (aligned_w),
    .rf_we_o   (rf_we_w)
  );

  // A response is ours only once every outstanding cancelled one has drained.
  always_comb begin
    wait_w    = ms_valid_q && pl_q.req_sent && !buf_valid_q;
    stale_ok  = bus.data_data_ok && (cnt_q != '0);
    resp_mine = bus.data_data_ok && (cnt_q == '0) && wait_w;
    ready_go  = !wait_w || resp_mine;
    allowin   = !ms_valid_q || (ready_go && bus.ws_allowin);
    leave     = ms_valid_q && ready_go && bus.ws_allowin;
  end

  always_comb begin
    pl_d        = pl_q;
    ms_valid_d  = ms_valid_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    cnt_sum     = {1'b0, cnt_q};
    if (bus.flush) begin
      ms_valid_d  = 1'b0;
      buf_valid_d = 1'b0;
      cnt_sum     = cnt_sum + {{CANCEL_W{1'b0}}, (wait_w && !resp_mine)}
                            + {{CANCEL_W{1'b0}}, bus.es_cancel_req};
    end else begin
      if (allowin) begin
        ms_valid_d = bus.es_to_ms_valid;
        if (bus.es_to_ms_valid) begin
          pl_d.pc           = bus.es_pc;
          pl_d.addr_low     = bus.es_addr_low;
          pl_d.load_op      = load_op_e'(bus.es_load_op);
          pl_d.res_from_mem = bus.es_res_from_mem;
          pl_d.req_sent     = bus.es_req_sent;
          pl_d.gr_we        = bus.es_gr_we;
          pl_d.dest         = bus.es_dest;
          pl_d.alu_result   = bus.es_alu_result;
        end
      end
      if (leave) begin
        buf_valid_d = 1'b0;
      end else if (resp_mine && !bus.ws_allowin) begin
        buf_valid_d = 1'b1;
        buf_data_d  = lane_w;
      end
    end
    if (stale_ok) begin
      cnt_sum = cnt_sum - {{CANCEL_W{1'b0}}, 1'b1};
    end
    cnt_d = cnt_sum[CANCEL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pl_q        <= '0;
      ms_valid_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      pl_q        <= pl_d;
      ms_valid_q  <= ms_valid_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      cnt_q       <= cnt_d;
    end
  end

  // More cancelled requests in flight than the counter can hold is a system bug.
  a_cnt_no_overflow: assert property (@(posedge clk) disable iff (reset)
    cnt_sum <= {1'b0, {CANCEL_W{1'b1}}});

  assign bus.ms_allowin     = allowin;
  assign bus.ms_to_ws_valid = ms_valid_q && ready_go && !bus.flush;
  assign bus.ms_rf_we       = ms_valid_q ? rf_we_w : '0;
  assign bus.ms_dest        = pl_q.dest;
  assign bus.ms_result      = pl_q.res_from_mem ? aligned_w : pl_q.alu_result;
  assign bus.ms_pc          = pl_q.pc;
  assign bus.ms_valid       = ms_valid_q;
  assign bus.ms_fwd_valid   = ms_valid_q && pl_q.gr_we;
  assign bus.ms_fwd_block   = ms_valid_q && pl_q.res_from_mem && !ready_go;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a load/align vector table on a DW=32
// instance, DW=64 lane selection, and hand-written buffer/flush sequences.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_lsu_if #(.DW(32)) b32();
  mem_stage_lsu_if #(.DW(64)) b64();

  mem_stage_lsu #(.DW(32), .CANCEL_W(2)) u_dut32 (.clk(clk), .reset(reset), .bus(b32));
  mem_stage_lsu #(.DW(64), .CANCEL_W(2)) u_dut64 (.clk(clk), .reset(reset), .bus(b64));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [2:0]  op;
    logic        rfm;
    logic        req;
    logic        gwe;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] exp_res;
    logic [3:0]  exp_we;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle32();
    b32.flush = 0; b32.es_to_ms_valid = 0; b32.es_pc = 0; b32.es_addr_low = 0;
    b32.es_load_op = 0; b32.es_res_from_mem = 0; b32.es_req_sent = 0;
    b32.es_cancel_req = 0; b32.es_gr_we = 0; b32.es_dest = 0; b32.es_alu_result = 0;
    b32.data_rdata = 0; b32.data_data_ok = 0; b32.ws_allowin = 1;
  endtask

  task automatic idle64();
    b64.flush = 0; b64.es_to_ms_valid = 0; b64.es_pc = 0; b64.es_addr_low = 0;
    b64.es_load_op = 0; b64.es_res_from_mem = 0; b64.es_req_sent = 0;
    b64.es_cancel_req = 0; b64.es_gr_we = 0; b64.es_dest = 0; b64.es_alu_result = 0;
    b64.data_rdata = 0; b64.data_data_ok = 0; b64.ws_allowin = 1;
  endtask

  task automatic issue32(input logic [2:0] addr, input logic [2:0] op, input logic rfm,
                         input logic req, input logic gwe, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [4:0] dest);
    b32.es_to_ms_valid = 1; b32.es_addr_low = addr; b32.es_load_op = op;
    b32.es_res_from_mem = rfm; b32.es_req_sent = req; b32.es_gr_we = gwe;
    b32.es_alu_result = alu; b32.es_pc = pc; b32.es_dest = dest;
  endtask

  task automatic load64(input logic [2:0] addr, input logic [2:0] op,
                        input logic [63:0] rdata, input logic [31:0] exp, input string name);
    b64.es_to_ms_valid = 1; b64.es_addr_low = addr; b64.es_load_op = op;
    b64.es_res_from_mem = 1; b64.es_req_sent = 1; b64.es_gr_we = 1; b64.es_dest = 5'd7;
    tick();
    b64.es_to_ms_valid = 0; b64.data_data_ok = 1; b64.data_rdata = rdata;
    #1;
    chk({name, "_valid"}, {31'd0, b64.ms_to_ws_valid}, 32'd1);
    chk({name, "_result"}, b64.ms_result, exp);
    tick();
    b64.data_data_ok = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //           addr    op    rfm  req  gwe  alu           rdata         exp_res       we
    vecs[0]  = '{3'b011, 3'd1, 1'b1, 1'b1, 1'b1, 32'h0,        32'h80FF_1234, 32'hFFFF_FF80, 4'b1111};
    vecs[1]  = '{3'b010, 3'd2, 1'b1, 1'b1, 1'b1, 32'h0,        32'h80FF_1234, 32'h0000_00FF, 4'b1111};
    vecs[2]  = '{3'b010, 3'd3, 1'b1, 1'b1, 1'b1, 32'h0,        32'h80FF_1234, 32'hFFFF_80FF, 4'b1111};
    vecs[3]  = '{3'b000, 3'd4, 1'b1, 1'b1, 1'b1, 32'h0,        32'h80FF_1234, 32'h0000_1234, 4'b1111};
    vecs[4]  = '{3'b000, 3'd0, 1'b1, 1'b1, 1'b1, 32'h0,        32'h80FF_1234, 32'h80FF_1234, 4'b1111};
    vecs[5]  = '{3'b001, 3'd5, 1'b1, 1'b1, 1'b1, 32'h0,        32'hAABB_CCDD, 32'hCCDD_0000, 4'b1100};
    vecs[6]  = '{3'b010, 3'd6, 1'b1, 1'b1, 1'b1, 32'h0,        32'hAABB_CCDD, 32'h0000_AABB, 4'b0011};
    vecs[7]  = '{3'b000, 3'd5, 1'b1, 1'b1, 1'b1, 32'h0,        32'hAABB_CCDD, 32'hDD00_0000, 4'b1000};
    vecs[8]  = '{3'b011, 3'd6, 1'b1, 1'b1, 1'b1, 32'h0,        32'hAABB_CCDD, 32'h0000_00AA, 4'b0001};
    vecs[9]  = '{3'b000, 3'd7, 1'b1, 1'b1, 1'b1, 32'h0,        32'hAABB_CCDD, 32'hAABB_CCDD, 4'b1111};
    vecs[10] = '{3'b000, 3'd0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h0,        32'h1234_5678, 4'b1111};
    vecs[11] = '{3'b100, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,        32'h0000_0100, 4'b0000};

    idle32();
    idle64();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;
    chk("rst_to_ws_valid", {31'd0, b32.ms_to_ws_valid}, 32'd0);
    chk("rst_rf_we",       {28'd0, b32.ms_rf_we}, 32'd0);
    chk("rst_result",      b32.ms_result, 32'd0);
    chk("rst_pc",          b32.ms_pc, 32'd0);
    chk("rst_fwd_valid",   {31'd0, b32.ms_fwd_valid}, 32'd0);
    chk("rst_fwd_block",   {31'd0, b32.ms_fwd_block}, 32'd0);
    chk("rst_allowin",     {31'd0, b32.ms_allowin}, 32'd1);
    chk("rst64_result",    b64.ms_result, 32'd0);

    for (int i = 0; i < 12; i++) begin
      issue32(vecs[i].addr, vecs[i].op, vecs[i].rfm, vecs[i].req, vecs[i].gwe,
              vecs[i].alu, 32'h0040_0000 + 32'(i * 4), 5'(i + 1));
      tick();
      b32.es_to_ms_valid = 0;
      #1;
      chk($sformatf("v%0d_block_pre", i), {31'd0, b32.ms_fwd_block},
          {31'd0, vecs[i].rfm & vecs[i].req});
      chk($sformatf("v%0d_valid_pre", i), {31'd0, b32.ms_to_ws_valid}, {31'd0, ~vecs[i].req});
      if (vecs[i].req) begin
        b32.data_data_ok = 1;
        b32.data_rdata   = vecs[i].rdata;
      end
      #1;
      chk($sformatf("v%0d_valid", i),   {31'd0, b32.ms_to_ws_valid}, 32'd1);
      chk($sformatf("v%0d_result", i),  b32.ms_result, vecs[i].exp_res);
      chk($sformatf("v%0d_rf_we", i),   {28'd0, b32.ms_rf_we}, {28'd0, vecs[i].exp_we});
      chk($sformatf("v%0d_pc", i),      b32.ms_pc, 32'h0040_0000 + 32'(i * 4));
      chk($sformatf("v%0d_dest", i),    {27'd0, b32.ms_dest}, 32'(i + 1));
      chk($sformatf("v%0d_fwd_valid", i), {31'd0, b32.ms_fwd_valid}, {31'd0, vecs[i].gwe});
      chk($sformatf("v%0d_block", i),   {31'd0, b32.ms_fwd_block}, 32'd0);
      tick();
      b32.data_data_ok = 0;
      #1;
      chk($sformatf("v%0d_drained", i), {31'd0, b32.ms_valid}, 32'd0);
    end

    load64(3'b110, 3'd4, 64'h1234_5678_9ABC_DEF0, 32'h0000_1234, "d64_lhu");
    load64(3'b000, 3'd0, 64'h1234_5678_9ABC_DEF0, 32'h9ABC_DEF0, "d64_lw");
    load64(3'b101, 3'd1, 64'h1234_5678_9ABC_DEF0, 32'h0000_0056, "d64_lb");

    // Late response with WB stalled: must be buffered and survive bus changes.
    issue32(3'b000, 3'd0, 1, 1, 1, 32'h0, 32'h0000_2000, 5'd3);
    tick();
    b32.es_to_ms_valid = 0; b32.ws_allowin = 0;
    #1;
    chk("buf_block_wait", {31'd0, b32.ms_fwd_block}, 32'd1);
    chk("buf_valid_wait", {31'd0, b32.ms_to_ws_valid}, 32'd0);
    chk("buf_allowin_wait", {31'd0, b32.ms_allowin}, 32'd0);
    tick();
    tick();
    b32.data_data_ok = 1; b32.data_rdata = 32'hCAFE_BABE;
    #1;
    chk("buf_block_resp", {31'd0, b32.ms_fwd_block}, 32'd0);
    chk("buf_valid_resp", {31'd0, b32.ms_to_ws_valid}, 32'd1);
    chk("buf_allowin_resp", {31'd0, b32.ms_allowin}, 32'd0);
    tick();
    b32.data_data_ok = 0; b32.data_rdata = 32'hDEAD_DEAD;
    #1;
    chk("buf_hold1_result", b32.ms_result, 32'hCAFE_BABE);
    chk("buf_hold1_block", {31'd0, b32.ms_fwd_block}, 32'd0);
    tick();
    #1;
    chk("buf_hold2_result", b32.ms_result, 32'hCAFE_BABE);
    b32.ws_allowin = 1;
    #1;
    chk("buf_out_valid", {31'd0, b32.ms_to_ws_valid}, 32'd1);
    chk("buf_out_result", b32.ms_result, 32'hCAFE_BABE);
    chk("buf_out_allowin", {31'd0, b32.ms_allowin}, 32'd1);
    tick();
    chk("buf_drained", {31'd0, b32.ms_valid}, 32'd0);

    // Flush with a waiting load and another request in EX: two responses are stale.
    issue32(3'b000, 3'd0, 1, 1, 1, 32'h0, 32'h0000_3000, 5'd4);
    tick();
    b32.es_to_ms_valid = 0; b32.flush = 1; b32.es_cancel_req = 1;
    #1;
    chk("fl_valid", {31'd0, b32.ms_to_ws_valid}, 32'd0);
    tick();
    b32.flush = 0; b32.es_cancel_req = 0;
    #1;
    chk("fl_empty", {31'd0, b32.ms_valid}, 32'd0);
    issue32(3'b000, 3'd0, 1, 1, 1, 32'h0, 32'h0000_3004, 5'd5);
    tick();
    b32.es_to_ms_valid = 0; b32.data_data_ok = 1; b32.data_rdata = 32'h1111_1111;
    #1;
    chk("fl_stale1_valid", {31'd0, b32.ms_to_ws_valid}, 32'd0);
    chk("fl_stale1_block", {31'd0, b32.ms_fwd_block}, 32'd1);
    tick();
    b32.data_rdata = 32'h2222_2222;
    #1;
    chk("fl_stale2_valid", {31'd0, b32.ms_to_ws_valid}, 32'd0);
    chk("fl_stale2_occupied", {31'd0, b32.ms_valid}, 32'd1);
    tick();
    b32.data_rdata = 32'h3333_3333;
    #1;
    chk("fl_mine_valid", {31'd0, b32.ms_to_ws_valid}, 32'd1);
    chk("fl_mine_result", b32.ms_result, 32'h3333_3333);
    tick();
    b32.data_data_ok = 0;
    #1;
    chk("fl_drained", {31'd0, b32.ms_valid}, 32'd0);

    // Flush coinciding with our own response: nothing becomes stale.
    issue32(3'b000, 3'd0, 1, 1, 1, 32'h0, 32'h0000_4000, 5'd6);
    tick();
    b32.es_to_ms_valid = 0; b32.flush = 1; b32.data_data_ok = 1; b32.data_rdata = 32'h4444_4444;
    #1;
    chk("flm_valid", {31'd0, b32.ms_to_ws_valid}, 32'd0);
    tick();
    b32.flush = 0; b32.data_data_ok = 0;
    #1;
    chk("flm_empty", {31'd0, b32.ms_valid}, 32'd0);
    issue32(3'b000, 3'd0, 1, 1, 1, 32'h0, 32'h0000_4004, 5'd6);
    tick();
    b32.es_to_ms_valid = 0; b32.data_data_ok = 1; b32.data_rdata = 32'h5555_5555;
    #1;
    chk("flm_next_valid", {31'd0, b32.ms_to_ws_valid}, 32'd1);
    chk("flm_next_result", b32.ms_result, 32'h5555_5555);
    tick();
    b32.data_data_ok = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
